fir_inverse: RTL and testbench

Streaming inverse (deconvolution) filter for the 4-tap FIR in the same datapath (taps 1, 2, 3, 4; output truncated to 8 bits). It accepts the FIR's 8-bit output samples y[n] and exactly recovers the original 8-bit input x[n] modulo 256: x[n] = y[n] − C1·x[n−1] − C2·x[n−2] − C3·x[n−3]. Exact recovery is possible because tap 0 is 1. It uses one time-shared multiplier driven by a small FSM, with valid/ready handshakes on both sides, and sits at the receive end of the filtered link.

---
 rtl/fir_inverse.sv | 125 ++++++++++++
 tb/tb_fir_inverse.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_inverse.sv
// Streaming deconvolution filter: recovers x[n] from the 4-tap FIR output y[n]
// using one time-shared 8x8 multiplier, all arithmetic wrapping mod 256.
module fir_inverse #(
  parameter logic [7:0] C1 = 8'd2,
  parameter logic [7:0] C2 = 8'd3,
  parameter logic [7:0] C3 = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [7:0] acc, acc_nxt;
  logic [7:0] h0, h1, h2;
  logic [7:0] h0_nxt, h1_nxt, h2_nxt;
  logic [7:0] out_data_nxt;
  logic       in_ready_nxt, out_valid_nxt;

  logic [7:0] coef, hsel, prod, diff;

  // Tap select for the shared multiplier: Ck pairs with h(k-1)
  always_comb begin
    coef = C3;
    hsel = h2;
    case (k)
      2'd1: begin
        coef = C1;
        hsel = h0;
      end
      2'd2: begin
        coef = C2;
        hsel = h1;
      end
      default: begin
        coef = C3;
        hsel = h2;
      end
    endcase
  end

  // Truncating multiply and subtract: wrap-around is what makes inversion exact
  assign prod = coef * hsel;
  assign diff = acc - prod;

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    acc_nxt      = acc;
    h0_nxt       = h0;
    h1_nxt       = h1;
    h2_nxt       = h2;
    out_data_nxt = out_data;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nxt   = in_data;
          k_nxt     = 2'd1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        acc_nxt = diff;
        if (k == 2'd3) begin
          k_nxt        = 2'd1;
          out_data_nxt = diff;
          state_nxt    = OUT;
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      OUT: begin
        // History advances only on the output handshake so stalls are harmless
        if (out_ready) begin
          h2_nxt    = h1;
          h1_nxt    = h0;
          h0_nxt    = acc;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= 2'd1;
      acc       <= 8'd0;
      h0        <= 8'd0;
      h1        <= 8'd0;
      h2        <= 8'd0;
      out_data  <= 8'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      acc       <= acc_nxt;
      h0        <= h0_nxt;
      h1        <= h1_nxt;
      h2        <= h2_nxt;
      out_data  <= out_data_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fir_inverse.sv
// Bench for fir_inverse: directed cases plus a random stream pushed through a
// behavioural 4-tap FIR, with protocol checks done by a negedge monitor.
module tb_fir_inverse;

  typedef logic [7:0] q8_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  rnd_hs = 1'b0;
  q8_t got;

  fir_inverse dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit-accurate upstream FIR, both ends starting from zero history
  function automatic void fir_model(input q8_t x, output q8_t y);
    int xm1 = 0, xm2 = 0, xm3 = 0;
    y = {};
    foreach (x[i]) begin
      y.push_back(8'(int'(x[i]) + 2 * xm1 + 3 * xm2 + 4 * xm3));
      xm3 = xm2;
      xm2 = xm1;
      xm1 = int'(x[i]);
    end
  endfunction

  // Random output backpressure while enabled
  always @(posedge clk) begin
    #1;
    if (rnd_hs) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Protocol monitor: latency, accept spacing, stall stability, output capture
  int   acc_edge = 0;
  bit   have_acc = 1'b0;
  bit   prev_ov = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] stall_data = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      have_acc   = 1'b0;
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && !prev_ov) check("latency", 32'(cyc - acc_edge), 32'd3);
      if (in_valid && in_ready) begin
        if (have_acc) check("accept_spacing", 32'((cyc + 1 - acc_edge) >= 5), 32'd1);
        acc_edge = cyc + 1;
        have_acc = 1'b1;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      stall_data = out_data;
      prev_ov    = out_valid;
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    got.delete();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold in_valid until it is taken
  task automatic feed(input logic [7:0] y);
    int  n = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = y;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run(input string tag, input q8_t y, input q8_t exp, input bit random_hs);
    int t = 0;
    got.delete();
    rnd_hs = random_hs;
    foreach (y[i]) begin
      if (random_hs) begin
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk);
          #1;
        end
      end
      feed(y[i]);
    end
    while (got.size() < exp.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    rnd_hs = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) check({tag, "_data"}, 32'(got[i]), 32'(exp[i]));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    q8_t y, e, xs;
    int  t;

    do_reset();

    // Impulse response of the FIR inverts back to a unit impulse
    y = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
    e = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run("impulse", y, e, 1'b0);

    // Modulo-256 wrap-around
    do_reset();
    y = '{8'd200, 8'd244};
    e = '{8'd200, 8'd100};
    run("wrap", y, e, 1'b0);
    do_reset();
    y = '{8'd255};
    e = '{8'd255};
    run("wrap255", y, e, 1'b0);

    // Backpressure: output held for 10 cycles
    do_reset();
    out_ready = 1'b0;
    feed(8'd7);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_handshakes", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("bp_out", 32'(got[0]), 32'd7);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset during the second MAC cycle, with nonzero history (h0=7)
    got.delete();
    feed(8'd9);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_output", 32'(got.size()), 32'd0);
    @(posedge clk);
    #1;
    y = '{8'd5};
    e = '{8'd5};
    run("midrst_next", y, e, 1'b0);

    // Random stream through the FIR model, first free-running then with handshakes
    xs = {};
    for (int i = 0; i < 1000; i++) xs.push_back(8'($urandom));
    fir_model(xs, y);
    do_reset();
    run("rand_stream", y, xs, 1'b0);
    do_reset();
    run("rand_hs", y, xs, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
